rf_sync_fifo: RTL and testbench
===============================

// Module: rf_sync_fifo
// PURPOSE
//  Parametrised single-clock FIFO built on a write-synchronous, read-asynchronous register file.
//  Generalises the fixed 4x10 register file to WIDTH x DEPTH storage with pointers, flags and a fill level.
//  Read is first-word-fall-through (FWFT): the head word is always visible on RDATAOUT.
//  Sits between camera/line-buffer producers and SPI/I2S consumers on the iCE40UP fabric, mapped to LUT storage, not EBR.
// PARAMETERS
//  WIDTH        10  data word width in bits, >=1
//  DEPTH        4   number of entries; power of two, >=2
//  AFULL_THRESH 3   AFULL is asserted when LEVEL >= AFULL_THRESH; range 1..DEPTH
// PORTS
//  CLK        in   1              single clock; all state changes on its rising edge
//  RSTN       in   1              asynchronous active-low reset; release is synchronous to CLK
//  WDATAIN    in   WIDTH          push data
//  WE         in   1              push request
//  RE         in   1              pop request (acknowledges the current RDATAOUT)
//  RDATAOUT   out  WIDTH          head-of-queue word, combinational from the storage at rd_ptr
//  EMPTY      out  1              no valid entries
//  FULL       out  1              DEPTH valid entries
//  AFULL      out  1              LEVEL >= AFULL_THRESH
//  LEVEL      out  clog2(DEPTH)+1 number of valid entries, 0..DEPTH
// BEHAVIOUR
//  - Pointers: wr_ptr and rd_ptr are AW+1 bits wide (AW = clog2(DEPTH)). The MSB is a wrap bit; the low AW bits address storage.
//  - EMPTY = (wr_ptr == rd_ptr). FULL = low bits equal and MSBs differ. LEVEL = wr_ptr - rd_ptr (modulo 2^(AW+1)).
//  - Reset (RSTN=0, asynchronous): both pointers = 0, so EMPTY=1, FULL=0, AFULL=0 and LEVEL=0. Storage contents are not reset.
//  - push_ok = WE & (~FULL | RE). A pop at FULL frees a slot in the same cycle.
//  - pop_ok  = RE & ~EMPTY. A pop at EMPTY is ignored, even if WE is also asserted.
//  - On push_ok: mem[wr_ptr[AW-1:0]] <= WDATAIN; wr_ptr increments.
//  - On pop_ok: rd_ptr increments.
//  - Push+pop at FULL: both succeed; LEVEL stays DEPTH.
//  - Push+pop at EMPTY: only the push occurs; LEVEL becomes 1.
//  - Push-to-read latency: a word written at edge N appears on RDATAOUT, with EMPTY=0, after edge N (one cycle).
//  - RDATAOUT while EMPTY: don't-care. It shows mem[rd_ptr] and must not be relied on.
//  - Wrap-around: pointers wrap naturally at 2^(AW+1). No entry is lost or duplicated across a wrap.
//  - All flags come from registered pointers only, with no combinational path from WE/RE. RDATAOUT depends only on rd_ptr and storage.
//  - Reset asserted mid-operation: pointers clear immediately and all in-flight data is discarded.
// CONFIGURATION
//  RF_SYNC_FIFO_ERRFLAG_EN: when defined, adds these ports:
//    ERR_CLR in 1    synchronous clear of both flags; has priority over a same-cycle set
//    OVF     out 1   sticky; set when WE & ~push_ok (write refused at FULL)
//    UDF     out 1   sticky; set when RE & EMPTY (pop refused)
//  Both flags reset to 0. When the macro is undefined, these ports and their logic are absent; FIFO behaviour is otherwise identical.
// STRUCTURE
//  - Shared package rf_fifo_pkg holds:
//      clog2 constant function;
//      pointer-width localparam rule (AW+1);
//      common flag encoding, reused by the future async-FIFO variant.
//  - One sub-module: rf_mem. It is the parametrised WIDTH x DEPTH register file (sync write on CLK with WE, async read by address).
//  - Pointer, flag and level logic lives in rf_sync_fifo.
// TESTING
//  1. Reset, then idle: EMPTY=1, FULL=0, AFULL=0, LEVEL=0. Assert RSTN low mid-fill at LEVEL=2: all flags return to reset values without waiting for a CLK edge.
//  2. Defaults (10x4): push 0x001..0x004 -> FULL=1, LEVEL=4, AFULL=1 after the 3rd push, RDATAOUT=0x001. Then pop 4 times -> outputs 0x001..0x004 in order, then EMPTY=1.
//  3. At FULL, WE=1 and RE=1 with WDATAIN=0x3FF -> LEVEL stays 4, head advances, 0x3FF is read out 4 pops later.
//  4. At EMPTY, WE=1 and RE=1 with WDATAIN=0x155 -> next cycle LEVEL=1 and RDATAOUT=0x155. With ERRFLAG_EN, UDF=1.
//  5. 1000 cycles of random WE/RE with DEPTH=8, WIDTH=16 against a scoreboard queue -> zero mismatches. LEVEL equals model depth every cycle; multiple wraps observed.
//  6. ERRFLAG_EN: WE at FULL -> OVF=1 and holds; ERR_CLR plus overflow in the same cycle -> OVF=0. Without the macro: build contains no OVF/UDF ports.

Source files
------------

// File: rtl/rf_fifo_pkg.sv
// Shared FIFO helpers: ceil-log2, pointer-width rule and the common flag encoding.
// Used by rf_sync_fifo and rf_mem; intended for reuse by the async-FIFO variant.
package rf_fifo_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // One extra wrap bit above the storage address distinguishes full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic afull;
    } fifo_flags_t;

endpackage : rf_fifo_pkg

// File: rtl/rf_mem.sv
// WIDTH x DEPTH register file: synchronous write, asynchronous read.
// Storage is deliberately left unreset so it maps onto plain LUT storage.
module rf_mem
    import rf_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [clog2(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [clog2(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : rf_mem

// File: rtl/rf_sync_fifo.sv
// Single-clock first-word-fall-through FIFO over rf_mem with flags and fill level.
// Optional sticky OVF/UDF error flags with ERR_CLR when RF_SYNC_FIFO_ERRFLAG_EN is defined.
module rf_sync_fifo
    import rf_fifo_pkg::*;
#(
    parameter int unsigned WIDTH        = 10,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AFULL_THRESH = 3
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic [WIDTH-1:0]        WDATAIN,
    input  logic                    WE,
    input  logic                    RE,
    output logic [WIDTH-1:0]        RDATAOUT,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic                    AFULL,
    output logic [clog2(DEPTH):0]   LEVEL
`ifdef RF_SYNC_FIFO_ERRFLAG_EN
    ,
    input  logic                    ERR_CLR,
    output logic                    OVF,
    output logic                    UDF
`endif
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] level_c;
    fifo_flags_t   flags_c;
    logic          push_ok_c;
    logic          pop_ok_c;

    // Flags and level depend only on the registered pointers.
    always_comb begin
        level_c       = wr_ptr - rd_ptr;
        flags_c.empty = (wr_ptr == rd_ptr);
        flags_c.full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        flags_c.afull = (level_c >= PW'(AFULL_THRESH));
    end

    // A pop at FULL frees a slot for a same-cycle push; a pop at EMPTY is dropped.
    assign push_ok_c = WE & (~flags_c.full | RE);
    assign pop_ok_c  = RE & ~flags_c.empty;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    rf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (CLK),
        .we    (push_ok_c),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (WDATAIN),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (RDATAOUT)
    );

    assign EMPTY = flags_c.empty;
    assign FULL  = flags_c.full;
    assign AFULL = flags_c.afull;
    assign LEVEL = level_c;

`ifdef RF_SYNC_FIFO_ERRFLAG_EN
    // Sticky error flags; clear wins over a same-cycle set.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            OVF <= 1'b0;
            UDF <= 1'b0;
        end else if (ERR_CLR) begin
            OVF <= 1'b0;
            UDF <= 1'b0;
        end else begin
            if (WE & ~push_ok_c) begin
                OVF <= 1'b1;
            end
            if (RE & flags_c.empty) begin
                UDF <= 1'b1;
            end
        end
    end
`endif

endmodule : rf_sync_fifo

// File: tb/tb_rf_sync_fifo.sv
// Directed and scoreboard checks for rf_sync_fifo (10x4 default and 16x8 instances).
// Exercises the OVF/UDF/ERR_CLR ports when RF_SYNC_FIFO_ERRFLAG_EN is defined.
module tb_rf_sync_fifo;

    logic        clk;
    logic        rstn;

    logic [9:0]  a_wdata;
    logic        a_we;
    logic        a_re;
    logic [9:0]  a_rdata;
    logic        a_empty;
    logic        a_full;
    logic        a_afull;
    logic [2:0]  a_level;

    logic [15:0] b_wdata;
    logic        b_we;
    logic        b_re;
    logic [15:0] b_rdata;
    logic        b_empty;
    logic        b_full;
    logic        b_afull;
    logic [3:0]  b_level;

`ifdef RF_SYNC_FIFO_ERRFLAG_EN
    logic        a_err_clr;
    logic        a_ovf;
    logic        a_udf;
    logic        b_err_clr;
    logic        b_ovf;
    logic        b_udf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    rf_sync_fifo #(
        .WIDTH        (10),
        .DEPTH        (4),
        .AFULL_THRESH (3)
    ) dut_a (
        .CLK      (clk),
        .RSTN     (rstn),
        .WDATAIN  (a_wdata),
        .WE       (a_we),
        .RE       (a_re),
        .RDATAOUT (a_rdata),
        .EMPTY    (a_empty),
        .FULL     (a_full),
        .AFULL    (a_afull),
        .LEVEL    (a_level)
`ifdef RF_SYNC_FIFO_ERRFLAG_EN
        ,
        .ERR_CLR  (a_err_clr),
        .OVF      (a_ovf),
        .UDF      (a_udf)
`endif
    );

    rf_sync_fifo #(
        .WIDTH        (16),
        .DEPTH        (8),
        .AFULL_THRESH (6)
    ) dut_b (
        .CLK      (clk),
        .RSTN     (rstn),
        .WDATAIN  (b_wdata),
        .WE       (b_we),
        .RE       (b_re),
        .RDATAOUT (b_rdata),
        .EMPTY    (b_empty),
        .FULL     (b_full),
        .AFULL    (b_afull),
        .LEVEL    (b_level)
`ifdef RF_SYNC_FIFO_ERRFLAG_EN
        ,
        .ERR_CLR  (b_err_clr),
        .OVF      (b_ovf),
        .UDF      (b_udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [9:0] d);
        a_we    = 1'b1;
        a_wdata = d;
        tick();
        a_we    = 1'b0;
    endtask

    task automatic pop_a_expect(input string tag, input logic [9:0] exp);
        check(tag, 32'(a_rdata), 32'(exp));
        a_re = 1'b1;
        tick();
        a_re = 1'b0;
    endtask

    logic [15:0] model_q[$];

    initial begin
        int n_push;
        int pw;
        bit m_push;
        bit m_pop;

        rstn    = 1'b0;
        a_we    = 1'b0;
        a_re    = 1'b0;
        a_wdata = '0;
        b_we    = 1'b0;
        b_re    = 1'b0;
        b_wdata = '0;
`ifdef RF_SYNC_FIFO_ERRFLAG_EN
        a_err_clr = 1'b0;
        b_err_clr = 1'b0;
`endif

        // Reset state
        repeat (2) tick();
        check("rst_empty", 32'(a_empty), 32'd1);
        check("rst_full",  32'(a_full),  32'd0);
        check("rst_afull", 32'(a_afull), 32'd0);
        check("rst_level", 32'(a_level), 32'd0);
        check("rst_b_empty", 32'(b_empty), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("idle_empty", 32'(a_empty), 32'd1);
        check("idle_level", 32'(a_level), 32'd0);

        // Fill to FULL, then drain in order
        for (int i = 1; i <= 4; i++) begin
            push_a(10'(i));
            check("fill_level", 32'(a_level), 32'(i));
            check("fill_afull", 32'(a_afull), (i >= 3) ? 32'd1 : 32'd0);
            check("fill_empty", 32'(a_empty), 32'd0);
        end
        check("fill_full",  32'(a_full),  32'd1);
        check("fill_head",  32'(a_rdata), 32'h001);
        for (int i = 1; i <= 4; i++) begin
            pop_a_expect("drain_data", 10'(i));
        end
        check("drain_empty", 32'(a_empty), 32'd1);
        check("drain_level", 32'(a_level), 32'd0);
        check("drain_full",  32'(a_full),  32'd0);

        // Simultaneous push+pop at FULL
        for (int i = 1; i <= 4; i++) push_a(10'(i));
        a_we = 1'b1; a_re = 1'b1; a_wdata = 10'h3FF;
        tick();
        a_we = 1'b0; a_re = 1'b0;
        check("fullpp_level", 32'(a_level), 32'd4);
        check("fullpp_full",  32'(a_full),  32'd1);
        check("fullpp_head",  32'(a_rdata), 32'h002);
        pop_a_expect("fullpp_d2", 10'h002);
        pop_a_expect("fullpp_d3", 10'h003);
        pop_a_expect("fullpp_d4", 10'h004);
        pop_a_expect("fullpp_d3ff", 10'h3FF);
        check("fullpp_empty", 32'(a_empty), 32'd1);

        // Simultaneous push+pop at EMPTY: only the push happens
        a_we = 1'b1; a_re = 1'b1; a_wdata = 10'h155;
        tick();
        a_we = 1'b0; a_re = 1'b0;
        check("emptypp_level", 32'(a_level), 32'd1);
        check("emptypp_data",  32'(a_rdata), 32'h155);
        check("emptypp_empty", 32'(a_empty), 32'd0);
`ifdef RF_SYNC_FIFO_ERRFLAG_EN
        check("emptypp_udf", 32'(a_udf), 32'd1);
        check("emptypp_ovf", 32'(a_ovf), 32'd0);
`endif
        pop_a_expect("emptypp_pop", 10'h155);

        // Asynchronous reset mid-fill at LEVEL=2
        push_a(10'h0AA);
        push_a(10'h0BB);
        check("midrst_pre_level", 32'(a_level), 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_empty", 32'(a_empty), 32'd1);
        check("midrst_level", 32'(a_level), 32'd0);
        check("midrst_full",  32'(a_full),  32'd0);
        check("midrst_afull", 32'(a_afull), 32'd0);
`ifdef RF_SYNC_FIFO_ERRFLAG_EN
        check("midrst_udf", 32'(a_udf), 32'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("postrst_empty", 32'(a_empty), 32'd1);

`ifdef RF_SYNC_FIFO_ERRFLAG_EN
        // Overflow is sticky; ERR_CLR wins over a same-cycle overflow
        for (int i = 1; i <= 4; i++) push_a(10'(i + 8));
        check("ovf_pre", 32'(a_ovf), 32'd0);
        push_a(10'h3AA);
        check("ovf_set",   32'(a_ovf),   32'd1);
        check("ovf_level", 32'(a_level), 32'd4);
        check("ovf_head",  32'(a_rdata), 32'h009);
        tick();
        check("ovf_hold", 32'(a_ovf), 32'd1);
        a_err_clr = 1'b1;
        push_a(10'h3BB);
        a_err_clr = 1'b0;
        check("ovf_clr", 32'(a_ovf), 32'd0);
        for (int i = 1; i <= 4; i++) pop_a_expect("ovf_drain", 10'(i + 8));
        check("ovf_drain_empty", 32'(a_empty), 32'd1);
`endif

        // Random push/pop on the 16x8 instance against a queue model
        n_push = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            pw = (((cyc / 100) % 2) == 0) ? 75 : 25;
            b_we    = ($urandom_range(0, 99) < 32'(pw));
            b_re    = ($urandom_range(0, 99) < 32'(100 - pw));
            b_wdata = 16'($urandom);
            #1;
            check("rnd_level", 32'(b_level), 32'(model_q.size()));
            check("rnd_empty", 32'(b_empty), (model_q.size() == 0) ? 32'd1 : 32'd0);
            check("rnd_full",  32'(b_full),  (model_q.size() == 8) ? 32'd1 : 32'd0);
            check("rnd_afull", 32'(b_afull), (model_q.size() >= 6) ? 32'd1 : 32'd0);
            if (model_q.size() != 0) begin
                check("rnd_data", 32'(b_rdata), 32'(model_q[0]));
            end
            m_push = b_we && ((model_q.size() < 8) || b_re);
            m_pop  = b_re && (model_q.size() != 0);
            tick();
            if (m_pop)  void'(model_q.pop_front());
            if (m_push) begin
                model_q.push_back(b_wdata);
                n_push++;
            end
        end
        b_we = 1'b0;
        b_re = 1'b0;
        check("rnd_wraps", (n_push >= 32) ? 32'd1 : 32'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rf_sync_fifo
